// File: rtl/vx_warp_ibuf.sv
// ============================================================================
// Module   : vx_warp_ibuf
// Brief    : Per-warp instruction FIFOs with round-robin issue to decode.
//            Optional perf stall counters enabled by defining IBUF_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef IBUF_SIZE
`define IBUF_SIZE 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef PC_BITS
`define PC_BITS 31
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif

module vx_warp_ibuf #(
    parameter int NUM_WARPS   = `NUM_WARPS,
    parameter int DEPTH       = `IBUF_SIZE,
    parameter int NUM_THREADS = `NUM_THREADS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [`NW_WIDTH-1:0]      in_wid,
    input  logic [`PC_BITS-1:0]       in_PC,
    input  logic [NUM_THREADS-1:0]    in_tmask,
    input  logic [31:0]               in_instr,
    input  logic [`UUID_WIDTH-1:0]    in_uuid,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [`NW_WIDTH-1:0]      out_wid,
    output logic [`PC_BITS-1:0]       out_PC,
    output logic [NUM_THREADS-1:0]    out_tmask,
    output logic [31:0]               out_instr,
    output logic [`UUID_WIDTH-1:0]    out_uuid,
    input  logic                      out_ready,
    output logic [NUM_WARPS-1:0]      ibuf_pop
`ifdef IBUF_PERF_EN
    ,
    output logic [31:0]               perf_in_stalls,
    output logic [31:0]               perf_out_stalls
`endif
);

    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_PW  = c_AW + 1;
    localparam int c_NWW = `NW_WIDTH;
    localparam int c_DW  = `PC_BITS + NUM_THREADS + 32 + `UUID_WIDTH;

    logic [c_DW-1:0]  r_mem_q    [NUM_WARPS][DEPTH];
    logic [c_PW-1:0]  r_wr_ptr_q [NUM_WARPS];
    logic [c_PW-1:0]  w_wr_ptr_d [NUM_WARPS];
    logic [c_PW-1:0]  r_rd_ptr_q [NUM_WARPS];
    logic [c_PW-1:0]  w_rd_ptr_d [NUM_WARPS];
    logic [c_NWW-1:0] r_rr_ptr_q, w_rr_ptr_d;
    logic [c_NWW-1:0] r_lock_wid_q, w_lock_wid_d;
    logic             r_lock_q, w_lock_d;

    logic [NUM_WARPS-1:0] w_empty, w_full;
    logic [c_NWW-1:0]     w_rr_wid, w_grant;
    logic                 w_rr_found, w_fire, w_push;
    logic [c_DW-1:0]      w_in_data, w_head;

    assign w_in_data = {in_PC, in_tmask, in_instr, in_uuid};

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_empty[w] = (r_wr_ptr_q[w] == r_rd_ptr_q[w]);
            w_full[w]  = (r_wr_ptr_q[w][c_AW] != r_rd_ptr_q[w][c_AW]) &&
                         (r_wr_ptr_q[w][c_AW-1:0] == r_rd_ptr_q[w][c_AW-1:0]);
        end
    end

    // Scan from the farthest offset down so the nearest non-empty warp wins.
    always_comb begin
        logic [c_NWW-1:0] idx;
        idx        = '0;
        w_rr_wid   = r_rr_ptr_q;
        w_rr_found = 1'b0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            idx = c_NWW'((int'(r_rr_ptr_q) + i) % NUM_WARPS);
            if (!w_empty[idx]) begin
                w_rr_wid   = idx;
                w_rr_found = 1'b1;
            end
        end
    end

    // A stalled grant is locked so out_* cannot change under decode.
    assign w_grant   = r_lock_q ? r_lock_wid_q : w_rr_wid;
    assign out_valid = r_lock_q || w_rr_found;
    assign w_fire    = out_valid && out_ready;
    assign w_head    = r_mem_q[w_grant][r_rd_ptr_q[w_grant][c_AW-1:0]];
    assign {out_PC, out_tmask, out_instr, out_uuid} = w_head;
    assign out_wid   = w_grant;
    assign in_ready  = !w_full[in_wid] || (w_fire && (w_grant == in_wid));
    assign w_push    = in_valid && in_ready;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            ibuf_pop[w] = w_fire && (w_grant == c_NWW'(w));
        end
    end

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_rr_ptr_d = r_rr_ptr_q;
        if (w_push) begin
            w_wr_ptr_d[in_wid] = r_wr_ptr_q[in_wid] + 1'b1;
        end
        if (w_fire) begin
            w_rd_ptr_d[w_grant] = r_rd_ptr_q[w_grant] + 1'b1;
            w_rr_ptr_d = (w_grant == c_NWW'(NUM_WARPS - 1)) ? '0 : w_grant + 1'b1;
        end
        w_lock_d     = out_valid && !out_ready;
        w_lock_wid_d = w_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q   <= '{default: '0};
            r_rd_ptr_q   <= '{default: '0};
            r_rr_ptr_q   <= '0;
            r_lock_q     <= 1'b0;
            r_lock_wid_q <= '0;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_rr_ptr_q   <= w_rr_ptr_d;
            r_lock_q     <= w_lock_d;
            r_lock_wid_q <= w_lock_wid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[in_wid][r_wr_ptr_q[in_wid][c_AW-1:0]] <= w_in_data;
        end
    end

`ifdef IBUF_PERF_EN
    logic [31:0] r_perf_in_q, w_perf_in_d;
    logic [31:0] r_perf_out_q, w_perf_out_d;

    always_comb begin
        w_perf_in_d  = r_perf_in_q;
        w_perf_out_d = r_perf_out_q;
        if (in_valid && !in_ready && (r_perf_in_q != '1)) begin
            w_perf_in_d = r_perf_in_q + 32'd1;
        end
        if (out_valid && !out_ready && (r_perf_out_q != '1)) begin
            w_perf_out_d = r_perf_out_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_in_q  <= '0;
            r_perf_out_q <= '0;
        end else begin
            r_perf_in_q  <= w_perf_in_d;
            r_perf_out_q <= w_perf_out_d;
        end
    end

    assign perf_in_stalls  = r_perf_in_q;
    assign perf_out_stalls = r_perf_out_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vx_warp_ibuf.sv
// ============================================================================
// Module   : tb_vx_warp_ibuf
// Brief    : Scoreboard bench for vx_warp_ibuf with a queue-based warp model.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef IBUF_SIZE
`define IBUF_SIZE 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef PC_BITS
`define PC_BITS 31
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif

module tb_vx_warp_ibuf;
    localparam int NW    = 4;
    localparam int DEPTH = 4;
    localparam int NT    = 4;

    typedef struct {
        logic [`PC_BITS-1:0]    pc;
        logic [NT-1:0]          tm;
        logic [31:0]            ins;
        logic [`UUID_WIDTH-1:0] uuid;
    } ent_t;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic [`NW_WIDTH-1:0]   in_wid;
    logic [`PC_BITS-1:0]    in_PC;
    logic [NT-1:0]          in_tmask;
    logic [31:0]            in_instr;
    logic [`UUID_WIDTH-1:0] in_uuid;
    logic                   in_ready;
    logic                   out_valid;
    logic [`NW_WIDTH-1:0]   out_wid;
    logic [`PC_BITS-1:0]    out_PC;
    logic [NT-1:0]          out_tmask;
    logic [31:0]            out_instr;
    logic [`UUID_WIDTH-1:0] out_uuid;
    logic                   out_ready;
    logic [NW-1:0]          ibuf_pop;
`ifdef IBUF_PERF_EN
    logic [31:0]            perf_in_stalls;
    logic [31:0]            perf_out_stalls;
`endif

    vx_warp_ibuf #(.NUM_WARPS(NW), .DEPTH(DEPTH), .NUM_THREADS(NT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_wid(in_wid), .in_PC(in_PC), .in_tmask(in_tmask),
        .in_instr(in_instr), .in_uuid(in_uuid), .in_ready(in_ready),
        .out_valid(out_valid), .out_wid(out_wid), .out_PC(out_PC), .out_tmask(out_tmask),
        .out_instr(out_instr), .out_uuid(out_uuid), .out_ready(out_ready),
        .ibuf_pop(ibuf_pop)
`ifdef IBUF_PERF_EN
        , .perf_in_stalls(perf_in_stalls), .perf_out_stalls(perf_out_stalls)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t exp_q [NW][$];
    int   m_rr = 0;
    bit   m_lock = 0;
    int   m_lock_wid = 0;
    int   m_in_st = 0;
    int   m_out_st = 0;
    bit   mon_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: the expected grant is the locked warp, else the first
    // non-empty model queue at or after the round-robin pointer.
    always @(negedge clk) begin
        bit            ev;
        bit            fire;
        bit            exp_rdy;
        int            g;
        int            w;
        logic [NW-1:0] ep;
        if (mon_en) begin
            ev = m_lock;
            g  = m_lock_wid;
            if (!m_lock) begin
                for (int i = 0; i < NW; i++) begin
                    w = (m_rr + i) % NW;
                    if (exp_q[w].size() > 0) begin
                        ev = 1;
                        g  = w;
                        break;
                    end
                end
            end
            chk("out_valid", 64'(out_valid), 64'(ev));
            if (ev && exp_q[g].size() > 0) begin
                chk("out_wid",   64'(out_wid),   64'(g));
                chk("out_PC",    64'(out_PC),    64'(exp_q[g][0].pc));
                chk("out_tmask", 64'(out_tmask), 64'(exp_q[g][0].tm));
                chk("out_instr", 64'(out_instr), 64'(exp_q[g][0].ins));
                chk("out_uuid",  64'(out_uuid),  64'(exp_q[g][0].uuid));
            end
            fire = ev && out_ready;
            ep = '0;
            if (fire) ep[g] = 1'b1;
            chk("ibuf_pop", 64'(ibuf_pop), 64'(ep));
            exp_rdy = (exp_q[in_wid].size() < DEPTH) || (fire && (g == int'(in_wid)));
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
`ifdef IBUF_PERF_EN
            chk("perf_in_stalls",  64'(perf_in_stalls),  64'(m_in_st));
            chk("perf_out_stalls", 64'(perf_out_stalls), 64'(m_out_st));
`endif
            if (reset) begin
                for (int k = 0; k < NW; k++) exp_q[k].delete();
                m_rr = 0; m_lock = 0; m_lock_wid = 0; m_in_st = 0; m_out_st = 0;
            end else begin
                if (in_valid && !exp_rdy) m_in_st++;
                if (ev && !out_ready) m_out_st++;
                if (fire) begin
                    void'(exp_q[g].pop_front());
                    m_rr   = (g + 1) % NW;
                    m_lock = 0;
                end else if (ev) begin
                    m_lock     = 1;
                    m_lock_wid = g;
                end
            end
        end
    end

    // Issue side: every accepted push becomes an expected entry for its warp.
    always @(negedge clk) begin
        ent_t e;
        #1;
        if (mon_en && !reset && in_valid && in_ready) begin
            e.pc = in_PC; e.tm = in_tmask; e.ins = in_instr; e.uuid = in_uuid;
            exp_q[in_wid].push_back(e);
        end
    end

    task automatic cyc(input bit v, input int w, input bit ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_wid    = 2'(w);
        out_ready = ordy;
        in_PC     = `PC_BITS'($urandom);
        in_tmask  = NT'($urandom);
        in_instr  = $urandom;
        in_uuid   = `UUID_WIDTH'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid  = 0;
        out_ready = 0;
        reset     = 1;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        int rr_seq [6];
        rr_seq = '{0, 0, 1, 1, 3, 3};
        reset = 1; in_valid = 0; in_wid = 0; in_PC = 0; in_tmask = 0;
        in_instr = 0; in_uuid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_ibuf_pop",  64'(ibuf_pop),  64'd0);
        mon_en = 1;

        // Single entry on warp 2
        cyc(1, 2, 1);
        in_PC = `PC_BITS'(32'h40000);
        in_instr = 32'h00000013;
        repeat (3) cyc(0, 0, 1);

        // Fill warp 1 with decode stalled, then release with a same-cycle push
        repeat (5) cyc(1, 1, 0);
        cyc(1, 1, 1);
        repeat (8) cyc(0, 0, 1);

        // Round-robin across warps 0, 1, 3
        for (int i = 0; i < 6; i++) cyc(1, rr_seq[i], 0);
        repeat (8) cyc(0, 0, 1);

        // Grant lock on warp 3 while warp 0 fills
        cyc(1, 3, 0);
        repeat (4) cyc(1, 0, 0);
        cyc(0, 0, 0);
        repeat (8) cyc(0, 0, 1);

        // Reset with entries queued
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        cyc(1, 2, 0);
        do_reset();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_ibuf_pop",  64'(ibuf_pop),  64'd0);
        for (int w = 0; w < NW; w++) begin
            in_wid = 2'(w);
            #1;
            chk("midrst_in_ready", 64'(in_ready), 64'd1);
        end

        // Stall counters: 10 output stalls, 3 input stalls
        do_reset();
        repeat (7) cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);
        @(posedge clk);
        #1;
        in_valid = 0;
`ifdef IBUF_PERF_EN
        #1;
        chk("perf_out_stalls_10", 64'(perf_out_stalls), 64'd10);
        chk("perf_in_stalls_3",   64'(perf_in_stalls),  64'd3);
`endif
        repeat (8) cyc(0, 0, 1);

        // Random traffic: a congested phase then a free-flowing phase
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, NW - 1), $urandom_range(0, 9) < 4);
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, NW - 1), $urandom_range(0, 3) != 0);
        repeat (30) cyc(0, 0, 1);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
